// File: rtl/svga_timing_pkg.sv
// SVGA 800x600 timing constants and the sync-lock state encoding.
// The transmit and receive sides both import this package.
package svga_timing_pkg;

    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_SYNC   = 120;
    localparam int SVGA_H_BACK   = 64;
    localparam int SVGA_H_TOTAL  = 1040;

    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_SYNC   = 6;
    localparam int SVGA_V_BACK   = 23;
    localparam int SVGA_V_TOTAL  = 666;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_H_LOCK   = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input and reports its rising and falling edges by
// comparing the current registered sample with the previous one.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sample;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sample <= sig;
            prev   <= sample;
        end
    end

    assign rise = sample & ~prev;
    assign fall = ~sample & prev;

endmodule

// File: rtl/svga_sync_decoder.sv
// Recovers pixel position and colour from an SVGA HSYNC/VSYNC stream, with a
// lock FSM that gates PIXEL_VALID and pulses SYNC_ERR when a locked stream breaks.
module svga_sync_decoder
    import svga_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BACK   = SVGA_H_BACK,
    parameter int H_TOTAL  = SVGA_H_TOTAL,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BACK   = SVGA_V_BACK,
    parameter int V_TOTAL  = SVGA_V_TOTAL
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic [7:0] COLOR_IN,
    output logic [9:0] X_PIXEL,
    output logic [9:0] Y_PIXEL,
    output logic [7:0] COLOR_OUT,
    output logic       PIXEL_VALID,
    output logic       FRAME_START,
    output logic       LOCKED,
    output logic       SYNC_ERR
);

    localparam logic [10:0] H_FIRST     = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_LAST      = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_FIRST     = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_LAST      = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [11:0] H_PERIOD    = 12'(H_TOTAL);
    localparam logic [11:0] H_PULSE     = 12'(H_SYNC);
    localparam logic [9:0]  V_LAST_LINE = 10'(V_TOTAL - 1);

    lock_state_t state;
    lock_state_t state_nxt;

    logic        h_rise;
    logic        h_fall;
    logic        v_rise;
    logic        v_fall_unused;
    logic [7:0]  color_q;
    logic [7:0]  color_d;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic        h_seen;
    logic        v_seen;
    logic        period_bad;
    logic [1:0]  good_cnt;
    logic        period_err;
    logic        pulse_err;
    logic        line_err;
    logic        frame_err;
    logic        good_rise;
    logic        active;

    sync_edge_detect u_hsync_edge (
        .clk   (CLK),
        .rst_n (RST_N),
        .sig   (HSYNC),
        .rise  (h_rise),
        .fall  (h_fall)
    );

    sync_edge_detect u_vsync_edge (
        .clk   (CLK),
        .rst_n (RST_N),
        .sig   (VSYNC),
        .rise  (v_rise),
        .fall  (v_fall_unused)
    );

    // hcnt/vcnt describe the same pixel as the edge pulses, one cycle behind
    // the input register; color_d keeps the colour aligned with them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            color_q    <= 8'd0;
            color_d    <= 8'd0;
            hcnt       <= 11'd0;
            vcnt       <= 10'd0;
            h_seen     <= 1'b0;
            v_seen     <= 1'b0;
            period_bad <= 1'b0;
        end else begin
            color_q <= COLOR_IN;
            color_d <= color_q;

            if (h_rise)
                hcnt <= 11'd0;
            else if (hcnt != '1)
                hcnt <= hcnt + 11'd1;

            if (v_rise)
                vcnt <= 10'd0;
            else if (h_rise && vcnt != '1)
                vcnt <= vcnt + 10'd1;

            if (h_rise)
                h_seen <= 1'b1;
            if (v_rise)
                v_seen <= 1'b1;

            if (h_rise)
                period_bad <= 1'b0;
            else if (pulse_err)
                period_bad <= 1'b1;
        end
    end

    assign period_err = h_rise && h_seen && (({1'b0, hcnt} + 12'd1) != H_PERIOD);
    assign pulse_err  = h_fall && (({1'b0, hcnt} + 12'd1) != H_PULSE);
    assign line_err   = period_err || pulse_err;
    assign frame_err  = v_rise && v_seen && (vcnt != V_LAST_LINE);
    // A line only counts toward lock if its whole period, pulse included, was clean.
    assign good_rise  = h_rise && h_seen && !period_bad && !line_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_UNLOCKED;
            good_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state != ST_UNLOCKED || line_err)
                good_cnt <= 2'd0;
            else if (good_rise)
                good_cnt <= good_cnt + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_UNLOCKED: begin
                if (good_rise && good_cnt == 2'd1)
                    state_nxt = ST_H_LOCK;
            end
            ST_H_LOCK: begin
                if (line_err || frame_err)
                    state_nxt = ST_UNLOCKED;
                else if (v_rise)
                    state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (line_err || frame_err)
                    state_nxt = ST_UNLOCKED;
            end
            default: state_nxt = ST_UNLOCKED;
        endcase
    end

    always_comb begin
        LOCKED   = (state == ST_LOCKED);
        SYNC_ERR = (state != ST_UNLOCKED) && (line_err || frame_err);
    end

    assign active = (state == ST_LOCKED) &&
                    (hcnt >= H_FIRST) && (hcnt < H_LAST) &&
                    (vcnt >= V_FIRST) && (vcnt < V_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            X_PIXEL     <= 10'd0;
            Y_PIXEL     <= 10'd0;
            COLOR_OUT   <= 8'd0;
            PIXEL_VALID <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            PIXEL_VALID <= active;
            FRAME_START <= active && (hcnt == H_FIRST) && (vcnt == V_FIRST);
            if (active) begin
                X_PIXEL   <= 10'(hcnt - H_FIRST);
                Y_PIXEL   <= vcnt - V_FIRST;
                COLOR_OUT <= color_d;
            end
        end
    end

endmodule

// File: tb/tb_svga_sync_decoder.sv
// Bench for svga_sync_decoder using a scaled-down raster so whole frames fit
// in a short run; a small transmitter drives COLOR = (x+y) mod 256.
module tb_svga_sync_decoder;

    localparam int HA = 8;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HT = 16;
    localparam int VA = 4;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = 10;
    localparam int HF = HS + HB;
    localparam int VF = VS + VB;

    typedef struct {
        bit act;
        int x;
        int y;
        int line;
        int h;
        int frame;
    } tx_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       HSYNC = 1'b0;
    logic       VSYNC = 1'b0;
    logic [7:0] COLOR_IN = 8'd0;
    logic [9:0] X_PIXEL;
    logic [9:0] Y_PIXEL;
    logic [7:0] COLOR_OUT;
    logic       PIXEL_VALID;
    logic       FRAME_START;
    logic       LOCKED;
    logic       SYNC_ERR;

    int  n_checks = 0;
    int  n_errors = 0;
    int  valid_cnt = 0;
    int  fs_cnt = 0;
    int  err_cnt = 0;
    int  tx_frame = 0;
    bit  lock_seen = 0;
    tx_t lock_at;
    tx_t cur;
    tx_t pipe0;
    tx_t pipe1;
    tx_t pipe2;

    svga_sync_decoder #(
        .H_ACTIVE (HA),
        .H_SYNC   (HS),
        .H_BACK   (HB),
        .H_TOTAL  (HT),
        .V_ACTIVE (VA),
        .V_SYNC   (VS),
        .V_BACK   (VB),
        .V_TOTAL  (VT)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .COLOR_IN    (COLOR_IN),
        .X_PIXEL     (X_PIXEL),
        .Y_PIXEL     (Y_PIXEL),
        .COLOR_OUT   (COLOR_OUT),
        .PIXEL_VALID (PIXEL_VALID),
        .FRAME_START (FRAME_START),
        .LOCKED      (LOCKED),
        .SYNC_ERR    (SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // pipe2 holds the transmitter pixel whose outputs are visible now; pipe1
    // the pixel whose sync edges the lock FSM has just acted on.
    always @(negedge CLK) begin
        if (!RST_N) begin
            checkOutput("reset_outputs",
                        {X_PIXEL, Y_PIXEL, COLOR_OUT, PIXEL_VALID, FRAME_START, LOCKED, SYNC_ERR},
                        32'd0);
        end else begin
            if (PIXEL_VALID) begin
                valid_cnt++;
                checkOutput("valid_in_active", 32'(pipe2.act), 32'd1);
                checkOutput("x_pixel", 32'(X_PIXEL), 32'(pipe2.x));
                checkOutput("y_pixel", 32'(Y_PIXEL), 32'(pipe2.y));
                checkOutput("color_out", 32'(COLOR_OUT), 32'((pipe2.x + pipe2.y) % 256));
            end
            if (FRAME_START) begin
                fs_cnt++;
                checkOutput("frame_start_pos",
                            pipe2.act ? 32'(pipe2.x * 1024 + pipe2.y) : 32'hFFFF_FFFF, 32'd0);
            end
            if (SYNC_ERR)
                err_cnt++;
            if (LOCKED && !lock_seen) begin
                lock_seen = 1;
                lock_at   = pipe1;
            end
        end
        pipe2 = pipe1;
        pipe1 = pipe0;
        pipe0 = cur;
    end

    task automatic applyStimulus(input int n_lines, input int bad_line, input int bad_len,
                                 input int bad_pulse, input int rst_line, input int rst_h);
        valid_cnt = 0;
        fs_cnt    = 0;
        err_cnt   = 0;
        for (int l = 0; l < n_lines; l++) begin
            int len;
            int pw;
            len = (l == bad_line) ? bad_len : HT;
            pw  = (l == bad_line) ? bad_pulse : HS;
            for (int h = 0; h < len; h++) begin
                @(posedge CLK);
                #1;
                if (l == rst_line && h == rst_h)
                    RST_N = 1'b0;
                else if (l == rst_line && h == rst_h + 3)
                    RST_N = 1'b1;
                HSYNC     = (h < pw);
                VSYNC     = (l < VS);
                cur.act   = (l >= VF) && (l < VF + VA) && (h >= HF) && (h < HF + HA);
                cur.x     = h - HF;
                cur.y     = l - VF;
                cur.line  = l;
                cur.h     = h;
                cur.frame = tx_frame;
                COLOR_IN  = cur.act ? 8'((cur.x + cur.y) % 256) : 8'hA5;
            end
        end
        tx_frame++;
    endtask

    task automatic holdSyncLow(input int cycles);
        valid_cnt = 0;
        fs_cnt    = 0;
        err_cnt   = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            #1;
            HSYNC    = 1'b0;
            VSYNC    = 1'b0;
            cur.act  = 0;
            COLOR_IN = 8'hA5;
        end
    endtask

    task automatic checkFrame(input string tag, input int exp_valid, input int exp_fs,
                              input int exp_err, input int exp_locked);
        checkOutput({tag, "_valid_cycles"}, 32'(valid_cnt), 32'(exp_valid));
        checkOutput({tag, "_frame_starts"}, 32'(fs_cnt), 32'(exp_fs));
        checkOutput({tag, "_sync_err"}, 32'(err_cnt), 32'(exp_err));
        checkOutput({tag, "_locked"}, 32'(LOCKED), 32'(exp_locked));
    endtask

    initial begin
        RST_N = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f0_acquire", 0, 0, 0, 0);

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f1_first_locked", HA * VA, 1, 0, 1);
        checkOutput("lock_seen", 32'(lock_seen), 32'd1);
        checkOutput("lock_frame", 32'(lock_at.frame), 32'd1);
        checkOutput("lock_line", 32'(lock_at.line), 32'd0);
        checkOutput("lock_h", 32'(lock_at.h), 32'd0);

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f2_nominal", HA * VA, 1, 0, 1);

        applyStimulus(VT, VF + 1, HT - 1, HS, -1, 0);
        checkFrame("f3_short_line", HA * 2, 1, 1, 0);

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f4_relock", HA * VA, 1, 0, 1);

        applyStimulus(VT, VF + 1, HT, HS - 1, -1, 0);
        checkFrame("f5_short_pulse", HA, 1, 1, 0);

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f6_relock", HA * VA, 1, 0, 1);

        applyStimulus(VT - 1, -1, 0, 0, -1, 0);
        checkFrame("f7_short_frame", HA * VA, 1, 0, 1);

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f8_frame_err", 0, 0, 1, 0);

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f9_relock", HA * VA, 1, 0, 1);

        applyStimulus(VT, -1, 0, 0, VF + 2, HF + 4);
        checkOutput("f10_reset_frame_starts", 32'(fs_cnt), 32'd1);
        checkOutput("f10_reset_sync_err", 32'(err_cnt), 32'd0);
        checkOutput("f10_reset_locked", 32'(LOCKED), 32'd0);

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f11_after_reset", HA * VA, 1, 0, 1);

        holdSyncLow(2100);
        checkFrame("stuck_hsync", 0, 0, 0, 1);

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f12_after_stuck", 0, 0, 1, 0);

        applyStimulus(VT, -1, 0, 0, -1, 0);
        checkFrame("f13_relock", HA * VA, 1, 0, 1);

        repeat (4) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
